// File: rtl/mxreg_read_port.sv
// Read port for the MX register bank: decodes the 8-bit register address map
// and streams register snapshots as valid/ready beats (single, pair or wrapping burst).
module mxreg_read_port #(
   parameter int unsigned WORD_LENGTH = 8,
   parameter int unsigned DEPTH       = 16
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [DEPTH-1:0][WORD_LENGTH-1:0]   reg_line,
   input  logic                                req_valid,
   output logic                                req_ready,
   input  logic [7:0]                          req_addr,
   input  logic                                req_burst,
   input  logic [3:0]                          req_len,
   output logic                                rsp_valid,
   input  logic                                rsp_ready,
   output logic [WORD_LENGTH-1:0]              rsp_data,
   output logic [3:0]                          rsp_idx,
   output logic                                rsp_last,
   output logic                                rsp_err
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                 state_q, state_d;
   logic [3:0]             len_q, len_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   pair_q, pair_d;
   logic [3:0]             alt_q, alt_d;
   logic                   valid_q, valid_d;
   logic [WORD_LENGTH-1:0] data_q, data_d;
   logic [3:0]             idx_q, idx_d;
   logic                   last_q, last_d;
   logic                   err_q, err_d;

   logic [3:0] dec_len, dec_first, dec_alt, nxt_idx;
   logic       dec_pair, dec_err;

   assign req_ready = (state_q == IDLE) && !rst;
   assign rsp_valid = valid_q;
   assign rsp_data  = data_q;
   assign rsp_idx   = idx_q;
   assign rsp_last  = last_q;
   assign rsp_err   = err_q;

   // Address decode; burst is honoured only in the plain range, ignored for the
   // FLAGS pairs, and turns 0x16/0x80 into an error beat.
   always_comb begin
      dec_len   = '0;
      dec_first = '0;
      dec_alt   = '0;
      dec_pair  = 1'b0;
      dec_err   = 1'b0;
      if (req_addr[7:4] == 4'h0) begin
         dec_first = req_addr[3:0];
         if (req_burst) dec_len = req_len;
      end else if (req_addr[7:2] == 6'b000100) begin
         dec_first = 4'd7;
         dec_alt   = {2'b00, req_addr[1:0]};
         dec_len   = 4'd1;
         dec_pair  = 1'b1;
      end else if (req_addr == 8'h16 && !req_burst) begin
         dec_first = 4'd6;
      end else if (req_addr == 8'h80 && !req_burst) begin
         dec_first = 4'd14;
         dec_alt   = 4'd6;
         dec_len   = 4'd1;
         dec_pair  = 1'b1;
      end else begin
         dec_err   = 1'b1;
      end
   end

   assign nxt_idx = pair_q ? alt_q : idx_q + 4'd1;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      pair_d  = pair_q;
      alt_d   = alt_q;
      valid_d = valid_q;
      data_d  = data_q;
      idx_d   = idx_q;
      last_d  = last_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               state_d = SEND;
               len_d   = dec_len;
               cnt_d   = '0;
               pair_d  = dec_pair;
               alt_d   = dec_alt;
               valid_d = 1'b1;
               idx_d   = dec_first;
               data_d  = dec_err ? '0 : reg_line[dec_first];
               last_d  = (dec_len == 4'd0);
               err_d   = dec_err;
            end
         end
         SEND: begin
            if (rsp_ready) begin
               if (last_q) begin
                  valid_d = 1'b0;
                  state_d = IDLE;
               end else begin
                  cnt_d  = cnt_q + 4'd1;
                  idx_d  = nxt_idx;
                  data_d = reg_line[nxt_idx];
                  last_d = ((cnt_q + 4'd1) == len_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         pair_q  <= 1'b0;
         alt_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         pair_q  <= pair_d;
         alt_q   <= alt_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_mxreg_read_port.sv
// Scoreboard bench for mxreg_read_port: expected beats are queued at request
// acceptance and compared by a monitor at each response handshake.
module tb_mxreg_read_port;

   typedef struct packed {
      logic [7:0] d;
      logic [3:0] idx;
      logic       last;
      logic       err;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [15:0][7:0]  regs;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [7:0]        req_addr  = '0;
   logic              req_burst = 1'b0;
   logic [3:0]        req_len   = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [7:0]        rsp_data;
   logic [3:0]        rsp_idx;
   logic              rsp_last;
   logic              rsp_err;

   beat_t exp_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   always #5 clk = ~clk;

   mxreg_read_port #(.WORD_LENGTH(8), .DEPTH(16)) dut (
      .clk(clk), .rst(rst), .reg_line(regs),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_burst(req_burst), .req_len(req_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_idx(rsp_idx), .rsp_last(rsp_last), .rsp_err(rsp_err)
   );

   // Monitor: every handshake pops one expected beat.
   always @(negedge clk) begin
      if (rsp_valid && rsp_ready && !rst) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL beat_unexpected: got idx=%0d data=%02h, required no beat", rsp_idx, rsp_data);
         end else begin
            beat_t e, a;
            e = exp_q.pop_front();
            a = '{d: rsp_data, idx: rsp_idx, last: rsp_last, err: rsp_err};
            if (a !== e)
               $display("FAIL beat: got data=%02h idx=%0d last=%b err=%b, required data=%02h idx=%0d last=%b err=%b",
                        a.d, a.idx, a.last, a.err, e.d, e.idx, e.last, e.err);
            else
               n_pass++;
         end
      end
   end

   task automatic push_exp(input logic [7:0] addr, input logic burst, input logic [3:0] len);
      logic [3:0] ix;
      int         n;
      if (addr < 8'h10) begin
         n = burst ? int'(len) + 1 : 1;
         for (int k = 0; k < n; k++) begin
            ix = addr[3:0] + 4'(k);
            exp_q.push_back('{d: regs[ix], idx: ix, last: (k == n - 1), err: 1'b0});
         end
      end else if (addr >= 8'h10 && addr <= 8'h13) begin
         ix = addr[3:0] - 4'h0;
         exp_q.push_back('{d: regs[7], idx: 4'd7, last: 1'b0, err: 1'b0});
         exp_q.push_back('{d: regs[ix], idx: ix, last: 1'b1, err: 1'b0});
      end else if (addr == 8'h16 && !burst) begin
         exp_q.push_back('{d: regs[6], idx: 4'd6, last: 1'b1, err: 1'b0});
      end else if (addr == 8'h80 && !burst) begin
         exp_q.push_back('{d: regs[14], idx: 4'd14, last: 1'b0, err: 1'b0});
         exp_q.push_back('{d: regs[6], idx: 4'd6, last: 1'b1, err: 1'b0});
      end else begin
         exp_q.push_back('{d: 8'h00, idx: 4'd0, last: 1'b1, err: 1'b1});
      end
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
   task automatic send_req(input logic [7:0] addr, input logic burst, input logic [3:0] len);
      req_valid = 1'b1;
      req_addr  = addr;
      req_burst = burst;
      req_len   = len;
      #1;
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL req_ready_idle: got %b, required 1", req_ready);
      else n_pass++;
      push_exp(addr, burst, len);
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b1) $display("FAIL latency: rsp_valid got %b, required 1", rsp_valid);
      else n_pass++;
   endtask

   // Ends at posedge+1 of the cycle after the final handshake.
   task automatic wait_done(input int budget);
      int c = 0;
      while (exp_q.size() != 0 && c < budget) begin
         @(posedge clk); #1;
         c++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         $display("FAIL timeout: got %0d beats outstanding, required 0", exp_q.size());
         exp_q.delete();
      end else n_pass++;
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
         $display("FAIL turnaround: got valid=%b ready=%b, required valid=0 ready=1", rsp_valid, req_ready);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({rsp_valid, rsp_data, rsp_idx, rsp_last, rsp_err, req_ready} !== 16'h0)
         $display("FAIL reset_state: got valid=%b data=%02h idx=%0d last=%b err=%b ready=%b, required all 0",
                  rsp_valid, rsp_data, rsp_idx, rsp_last, rsp_err, req_ready);
      else n_pass++;
      rst = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL reset_release: req_ready got %b, required 1", req_ready);
      else n_pass++;
   endtask

   task automatic test_single();
      regs[1] = 8'h5A;
      rsp_ready = 1'b1;
      send_req(8'h01, 1'b0, 4'd9);
      wait_done(5);
   endtask

   task automatic test_wrap_burst();
      logic [3:0] want;
      rsp_ready = 1'b1;
      send_req(8'h0E, 1'b1, 4'd3);
      for (int i = 0; i < 4; i++) begin
         want = 4'(14 + i);
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_idx !== want)
            $display("FAIL wrap_stream: got valid=%b idx=%0d, required valid=1 idx=%0d", rsp_valid, rsp_idx, want);
         else n_pass++;
         @(posedge clk); #1;
      end
      wait_done(2);
   endtask

   task automatic test_pair_backpressure();
      regs[7] = 8'h11;
      regs[2] = 8'h33;
      rsp_ready = 1'b0;
      send_req(8'h12, 1'b0, 4'd0);
      regs[7] = 8'h22;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== 8'h11 || rsp_idx !== 4'd7)
            $display("FAIL hold: got valid=%b data=%02h idx=%0d, required valid=1 data=11 idx=7", rsp_valid, rsp_data, rsp_idx);
         else n_pass++;
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      wait_done(5);
   endtask

   task automatic test_errors();
      rsp_ready = 1'b1;
      send_req(8'h14, 1'b0, 4'd0);
      wait_done(5);
      send_req(8'h80, 1'b1, 4'd3);
      wait_done(5);
      send_req(8'hFF, 1'b0, 4'd0);
      wait_done(5);
   endtask

   task automatic test_r2_insp();
      regs[14] = 8'hE4;
      regs[6]  = 8'h66;
      rsp_ready = 1'b1;
      send_req(8'h80, 1'b0, 4'd0);
      wait_done(5);
      send_req(8'h16, 1'b0, 4'd0);
      wait_done(5);
   endtask

   task automatic test_back_to_back();
      rsp_ready = 1'b1;
      send_req(8'h03, 1'b0, 4'd0);
      wait_done(5);
      send_req(8'h0F, 1'b1, 4'd1);
      wait_done(5);
      send_req(8'h10, 1'b0, 4'd0);
      wait_done(5);
   endtask

   task automatic test_reset_mid_burst();
      int c = 0;
      rsp_ready = 1'b1;
      send_req(8'h00, 1'b1, 4'd15);
      while (exp_q.size() > 13 && c < 20) begin
         @(posedge clk); #1;
         c++;
      end
      n_checks++;
      if (exp_q.size() != 13) $display("FAIL mid_progress: got %0d outstanding, required 13", exp_q.size());
      else n_pass++;
      rst = 1'b1;
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      exp_q.delete();
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0)
         $display("FAIL mid_abort: got valid=%b ready=%b, required valid=0 ready=0", rsp_valid, req_ready);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
         $display("FAIL mid_release: got ready=%b valid=%b, required ready=1 valid=0", req_ready, rsp_valid);
      else n_pass++;
      rsp_ready = 1'b1;
      send_req(8'h05, 1'b1, 4'd2);
      n_checks++;
      if (rsp_idx !== 4'd5) $display("FAIL mid_restart: got idx=%0d, required 5", rsp_idx);
      else n_pass++;
      wait_done(8);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) regs[i] = 8'(8'hA0 + i * 3);
      test_reset();
      @(posedge clk); #1;
      test_single();
      test_wrap_burst();
      test_pair_backpressure();
      test_errors();
      test_r2_insp();
      test_back_to_back();
      test_reset_mid_burst();
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mxreg_read_port.md
# mxreg_read_port

Read-side companion to the MX register bank: accepts read requests using the same 8-bit register address map that drives the load decoder, and returns register contents as a stream of beats over a valid/ready handshake. Pair addresses (FLAGS+GPR, R2+INSP) return two beats; plain addresses may request a wrapping burst of consecutive registers. It sits between the register bank's `reg_line` output and the debug/stack-save datapath, which consumes beats with backpressure.

## Interface
- WORD_LENGTH, 8, register width in bits
- DEPTH, 16, number of registers; the address map is defined only for 16

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- reg_line  in  DEPTH×WORD_LENGTH  live register contents, index 0=A … 15=R3
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_addr  in  8  register address
- req_burst  in  1  burst request; honoured only for addresses 0x00–0x0F
- req_len  in  4  burst beats minus 1 (beats = req_len+1, range 1..16)
- rsp_valid  out  1  beat present
- rsp_ready  in  1  consumer takes beat
- rsp_data  out  WORD_LENGTH  beat data
- rsp_idx  out  4  register index of this beat
- rsp_last  out  1  final beat of the request
- rsp_err  out  1  unmapped address; data is 0

## Operation
- Two-state FSM: IDLE, SEND. req_ready = (state==IDLE) && !rst.
- Accept in IDLE on req_valid&&req_ready: latch request, build beat list, load beat 0, go to SEND.
- Beat list by address:
  - 0x00–0x0F, req_burst=0: one beat, idx = addr[3:0].
  - 0x00–0x0F, req_burst=1: req_len+1 beats, idx = addr[3:0], +1 …, wrapping modulo 16 (0xF → 0x0).
  - 0x10–0x13: two beats, FLAGS (idx 7), then A/X/Y/D (idx 0..3); req_burst/req_len ignored.
  - 0x16: one beat, INSP (idx 6).
  - 0x80: two beats, R2 (idx 14), then INSP (idx 6).
  - Anything else, including req_burst with addr > 0x0F: one beat, rsp_err=1, rsp_data=0, rsp_idx=0.
- Loading a beat samples reg_line[idx] into rsp_data on that clock edge. The snapshot holds while rsp_valid && !rsp_ready, even if reg_line changes.
- On rsp_valid&&rsp_ready:
  - If not last: load the next beat on the same edge; rsp_valid stays 1.
  - If last: clear rsp_valid and return to IDLE.
- rsp_last=1 only on the final beat. rsp_err=1 only on the error beat.
- Output fields hold their values while rsp_valid=0 after a request completes; only rsp_valid is meaningful then.

## Timing
- Reset: state IDLE, rsp_valid=0, rsp_data=0, rsp_idx=0, rsp_last=0, rsp_err=0, internal beat counter=0. req_ready=0 while rst is high; req_ready=1 on the first cycle after rst deasserts.
- Latency: a request accepted at edge N gives rsp_valid=1 after edge N (cycle N+1).
- Throughput: with rsp_ready held high, one beat per cycle.
- Turnaround: last handshake at edge M; req_ready=1 in cycle M+1; the next request's first beat appears at M+2 at the earliest. Requests are never accepted while in SEND.
- Reset mid-burst: at the rst edge, abort the request; rsp_valid=0 from the next cycle; remaining beats are discarded.
- A reg_line change in the same cycle a beat loads: the beat captures the value present at that edge.
- req_len is ignored when req_burst=0.

## Test plan
- Single read: reg_line[1]=0x5A, req addr 0x01 → one beat one cycle after accept: data 0x5A, idx 1, last=1, err=0.
- Wrap burst: addr 0x0E, burst=1, len=3, rsp_ready=1 → beats with idx 14, 15, 0, 1 in four consecutive cycles; last only on idx 1; req_ready=1 on the following cycle.
- Pair and backpressure: addr 0x12, rsp_ready=0 for 3 cycles while reg_line[7] changes 0x11→0x22 after accept → beat 0 holds 0x11 (idx 7); after handshake, beat 1 is idx 2 with last=1.
- Errors: addr 0x14 → one beat, data 0, err=1, last=1. Burst with addr 0x80 → one error beat.
- R2+INSP: addr 0x80 → beats idx 14, then idx 6 with last=1. Addr 0x16 → single INSP beat.
- Reset mid-burst: 16-beat burst, rst asserted after beat 3 → rsp_valid=0 and req_ready=0 during rst; req_ready=1 the cycle after release; a new request starts cleanly at beat 0.
